// File: rtl/htif_mem_arb.sv
`default_nettype none
// ============================================================================
// htif_mem_arb : round-robin arbiter merging HTIF (r0) and debug/DMA (r1)
//                requesters onto one tagged memory port. Rev 1.0
// ============================================================================
module htif_mem_arb #(
   parameter int TAG_BITS = 4,
   parameter int MAX_RD   = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                r0_req_val,
   output logic                r0_req_rdy,
   input  logic                r0_req_op,
   input  logic [31:0]         r0_req_addr,
   input  logic [127:0]        r0_req_data,
   input  logic [TAG_BITS-2:0] r0_req_tag,
   output logic                r0_resp_val,
   output logic [127:0]        r0_resp_data,
   output logic [TAG_BITS-2:0] r0_resp_tag,
   input  logic                r1_req_val,
   output logic                r1_req_rdy,
   input  logic                r1_req_op,
   input  logic [31:0]         r1_req_addr,
   input  logic [127:0]        r1_req_data,
   input  logic [TAG_BITS-2:0] r1_req_tag,
   output logic                r1_resp_val,
   output logic [127:0]        r1_resp_data,
   output logic [TAG_BITS-2:0] r1_resp_tag,
   output logic                mem_req_val,
   input  logic                mem_req_rdy,
   output logic                mem_req_op,
   output logic [31:0]         mem_req_addr,
   output logic [127:0]        mem_req_data,
   output logic [TAG_BITS-1:0] mem_req_tag,
   input  logic                mem_resp_val,
   input  logic [127:0]        mem_resp_data,
   input  logic [TAG_BITS-1:0] mem_resp_tag,
   output logic                error
);
   localparam int CW = $clog2(MAX_RD + 1);

   typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t              state_q;
   logic                prio_q;
   logic [CW-1:0]       rd_cnt_q [2];
   logic [CW-1:0]       rd_cnt_d [2];
   logic                error_q;
   logic                error_d;
   logic                mem_req_val_q;
   logic                mem_req_op_q;
   logic [31:0]         mem_req_addr_q;
   logic [127:0]        mem_req_data_q;
   logic [TAG_BITS-1:0] mem_req_tag_q;

   logic [1:0] req_val;
   logic [1:0] req_op;
   logic [1:0] elig;
   logic [1:0] resp_hit;
   logic [1:0] inc;
   logic [1:0] dec;
   logic [1:0] spurious;
   logic       gnt_val;
   logic       gnt_id;

   assign req_val = {r1_req_val, r0_req_val};
   assign req_op  = {r1_req_op,  r0_req_op};

   // Priority holder wins when eligible; otherwise fall through to the other side.
   assign gnt_val = (state_q == IDLE) && (|elig);
   assign gnt_id  = prio_q ? elig[1] : ~elig[0];

   for (genvar n = 0; n < 2; n++) begin : g_req
      assign elig[n]     = req_val[n] && (req_op[n] || (rd_cnt_q[n] < CW'(MAX_RD)));
      assign resp_hit[n] = mem_resp_val && (mem_resp_tag[TAG_BITS-1] == 1'(n));
      assign inc[n]      = gnt_val && (gnt_id == 1'(n)) && !req_op[n];
      assign spurious[n] = resp_hit[n] && (rd_cnt_q[n] == '0);
      assign dec[n]      = resp_hit[n] && !spurious[n];
      assign rd_cnt_d[n] = (inc[n] && !dec[n]) ? rd_cnt_q[n] + CW'(1) :
                           (dec[n] && !inc[n]) ? rd_cnt_q[n] - CW'(1) : rd_cnt_q[n];
   end

   assign error_d = error_q | (|spurious);

   assign r0_req_rdy = rst_n && gnt_val && !gnt_id;
   assign r1_req_rdy = rst_n && gnt_val &&  gnt_id;

   assign r0_resp_val  = resp_hit[0];
   assign r1_resp_val  = resp_hit[1];
   assign r0_resp_data = mem_resp_data;
   assign r1_resp_data = mem_resp_data;
   assign r0_resp_tag  = mem_resp_tag[TAG_BITS-2:0];
   assign r1_resp_tag  = mem_resp_tag[TAG_BITS-2:0];

   assign mem_req_val  = mem_req_val_q;
   assign mem_req_op   = mem_req_op_q;
   assign mem_req_addr = mem_req_addr_q;
   assign mem_req_data = mem_req_data_q;
   assign mem_req_tag  = mem_req_tag_q;
   assign error        = error_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         prio_q         <= 1'b0;
         rd_cnt_q[0]    <= '0;
         rd_cnt_q[1]    <= '0;
         error_q        <= 1'b0;
         mem_req_val_q  <= 1'b0;
         mem_req_op_q   <= 1'b0;
         mem_req_addr_q <= '0;
         mem_req_data_q <= '0;
         mem_req_tag_q  <= '0;
      end else begin
         rd_cnt_q[0] <= rd_cnt_d[0];
         rd_cnt_q[1] <= rd_cnt_d[1];
         error_q     <= error_d;
         case (state_q)
            IDLE: begin
               if (gnt_val) begin
                  state_q        <= ISSUE;
                  prio_q         <= ~gnt_id;
                  mem_req_val_q  <= 1'b1;
                  mem_req_op_q   <= gnt_id ? r1_req_op   : r0_req_op;
                  mem_req_addr_q <= gnt_id ? r1_req_addr : r0_req_addr;
                  mem_req_data_q <= gnt_id ? r1_req_data : r0_req_data;
                  mem_req_tag_q  <= {gnt_id, (gnt_id ? r1_req_tag : r0_req_tag)};
               end
            end
            ISSUE: begin
               if (mem_req_rdy) begin
                  state_q       <= IDLE;
                  mem_req_val_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: doc/htif_mem_arb.md
HTIF_MEM_ARB -- requirements
Module: htif_mem_arb

Interface
REQ-001 Parameters SHALL be, one per line:
- TAG_BITS, default 4: memory-side tag width; the upstream tag is TAG_BITS-1 wide.
- MAX_RD, default 3: maximum outstanding reads per requester.
REQ-002 Ports SHALL be, one per line (N = 0,1):
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- rN_req_val  input  1  requester N request valid.
- rN_req_rdy  output  1  requester N request accepted this cycle.
- rN_req_op  input  1  0=read, 1=write.
- rN_req_addr  input  32  request address.
- rN_req_data  input  128  write data.
- rN_req_tag  input  TAG_BITS-1  requester tag.
- rN_resp_val  output  1  response valid to requester N.
- rN_resp_data  output  128  response data.
- rN_resp_tag  output  TAG_BITS-1  response tag.
- mem_req_val  output  1  memory request valid.
- mem_req_rdy  input  1  memory accepts request.
- mem_req_op  output  1  forwarded op.
- mem_req_addr  output  32  forwarded address.
- mem_req_data  output  128  forwarded data.
- mem_req_tag  output  TAG_BITS  {requester id, requester tag}.
- mem_resp_val  input  1  memory response valid.
- mem_resp_data  input  128  response data.
- mem_resp_tag  input  TAG_BITS  response tag, MSB = requester id.
- error  output  1  sticky protocol error.
REQ-003 Requester 0 SHALL be the HTIF port; requester 1 SHALL be the second (debug/DMA) master.

Function
REQ-004 FSM SHALL have two states: IDLE and ISSUE.
REQ-005 Eligibility: requester N SHALL be eligible when rN_req_val=1 and (rN_req_op=1 or rd_cnt[N] < MAX_RD).
REQ-006 In IDLE with at least one eligible requester:
- grant the eligible requester holding priority, else the other.
- assert rN_req_rdy=1 combinationally for the granted requester only, this cycle.
- latch op, addr, data and {N, tag} into the output register.
- go to ISSUE.
REQ-007 Outside REQ-006 conditions, rN_req_rdy SHALL be 0; in particular it is always 0 in ISSUE.
REQ-008 In ISSUE, mem_req_val SHALL be 1 and mem_req_* SHALL hold stable until mem_req_rdy=1; that cycle the FSM SHALL return to IDLE.
REQ-009 mem_req_val SHALL be 0 in IDLE; the sustained rate is one request per 2 cycles.
REQ-010 Round-robin: after a grant to N, priority SHALL move to requester 1-N.
REQ-011 Read counters (per requester, 2-bit for MAX_RD=3):
- increment rd_cnt[N] on a read grant.
- decrement on a valid response routed to N.
- on simultaneous grant and response for the same N, leave the count unchanged.
REQ-012 At rd_cnt[N]=MAX_RD, a read from N SHALL not be granted; writes from N SHALL remain grantable.
REQ-013 Response routing SHALL be combinational, zero latency: rN_resp_val = mem_resp_val AND mem_resp_tag[TAG_BITS-1]==N; rN_resp_data = mem_resp_data; rN_resp_tag = mem_resp_tag[TAG_BITS-2:0].
REQ-014 Writes SHALL expect no response.
REQ-015 A response routed to N with rd_cnt[N]=0 SHALL:
- set error=1 on the next cycle.
- still be forwarded.
- leave rd_cnt[N] at 0 (no underflow).
REQ-016 error SHALL remain 1 until reset.
REQ-017 A grant and a response in the same cycle SHALL both be processed independently.

Reset
REQ-018 When rst_n=0 at a posedge, the block SHALL:
- set state to IDLE.
- set priority to requester 0.
- clear rd_cnt[0] and rd_cnt[1] to 0.
- clear error to 0.
- clear mem_req_val to 0.
- clear the output register to 0.
REQ-019 While rst_n=0, rN_req_rdy SHALL be 0; rN_resp_val SHALL still follow mem_resp_val per REQ-013.
REQ-020 A reset during ISSUE SHALL discard the pending request; it is not reissued after reset.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Both requesters issue reads continuously from reset; mem_req_rdy=1 -> grants alternate 0,1,0,1; mem_req_tag MSB alternates; one mem_req_val every 2 cycles.
- r0 reads addr 0x1000 with tag 3; mem_req_rdy low for 5 cycles -> mem_req_addr=0x1000 and tag=0x3 stable all 5 cycles; r0_req_rdy pulses exactly once.
- r1 issues 4 reads with no responses -> 3 granted, 4th stalled; an r1 write is then granted; response tag 0xA -> r1_resp_val=1, r1_resp_tag=2, 4th read granted next IDLE.
- mem_resp_val=1 with tag 0x5 while rd_cnt[0]=0 -> r0_resp_val=1, error=1 next cycle and stays 1.
- Read grant to r0 in the same cycle as an r0 response, rd_cnt[0]=2 -> rd_cnt[0] remains 2.
- rst_n=0 during ISSUE -> mem_req_val=0 next cycle, counters 0, r0 holds priority after reset.
